pcie_rx_lane_descrambler: RTL and testbench

Per-lane PCIe receive descrambler between the PIPE lane receive stage and the lane-merge stage; one instance per lane, 16 lanes. It removes scrambling from 8b/10b (Gen1/2) and 128b/130b (Gen3+) symbol streams, passes K-codes and unscrambled ordered-set symbols through, and forwards valid, K flags and sync header with one cycle of latency.

---
 rtl/pcie_rx_lane_descrambler.sv | 228 ++++++++++++++++++++++
 tb/tb_pcie_rx_lane_descrambler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_lane_descrambler.sv
// pcie_rx_lane_descrambler: per-lane PCIe receive descrambler for 8b/10b (Gen1/2)
// and 128b/130b (Gen3+) symbol streams. Registered outputs, one cycle of latency.
module pcie_rx_lane_descrambler (
  input  logic        clk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic        PIPEDataValid,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [1:0]  PIPESyncHeader,
  input  logic [23:0] seedValue,
  input  logic [31:0] PIPEData,
  input  logic [3:0]  PIPEDataK,
  output logic        descramblerDataValid,
  output logic [31:0] descramblerData,
  output logic [3:0]  descramblerDataK,
  output logic [1:0]  descramblerSyncHeader
);

  localparam logic [15:0] POLY16  = 16'h0039;    // x^16 + x^5 + x^4 + x^3 + 1
  localparam logic [22:0] POLY23  = 23'h210125;  // x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1
  localparam logic [7:0]  K_COM   = 8'hBC;
  localparam logic [7:0]  K_SKP   = 8'h1C;
  localparam logic [7:0]  OS_SKP  = 8'hAA;
  localparam logic [7:0]  OS_EIE  = 8'h00;

  typedef struct packed {
    logic [15:0] l16;       // Gen1/2 scrambler state
    logic [22:0] l23;       // Gen3 scrambler state
    logic        com_seen;  // previous byte was a COM
    logic [3:0]  ts_cnt;    // remaining clear bytes of a TS ordered set
    logic [3:0]  byte_cnt;  // position inside a 128b/130b block
    logic        blk_os;    // current block is an ordered-set block
    logic        os_skp;    // current OS block is a SKP OS
    logic        os_eie;    // current OS block is an EIEOS
  } lane_state_t;

  localparam lane_state_t ST_INIT = '{l16: 16'hFFFF, l23: 23'd0, com_seen: 1'b0,
                                     ts_cnt: 4'd0, byte_cnt: 4'd0, blk_os: 1'b0,
                                     os_skp: 1'b0, os_eie: 1'b0};

  function automatic logic [15:0] adv16(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int unsigned i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ (r[15] ? POLY16 : '0);
    return r;
  endfunction

  function automatic logic [7:0] key16(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k = {r[15], k[7:1]};
      r = {r[14:0], 1'b0} ^ (r[15] ? POLY16 : '0);
    end
    return k;
  endfunction

  function automatic logic [22:0] adv23(input logic [22:0] s);
    logic [22:0] r;
    r = s;
    for (int unsigned i = 0; i < 8; i++) r = {r[21:0], 1'b0} ^ (r[22] ? POLY23 : '0);
    return r;
  endfunction

  function automatic logic [7:0] key23(input logic [22:0] s);
    logic [22:0] r;
    logic [7:0]  k;
    r = s;
    k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      k = {r[22], k[7:1]};
      r = {r[21:0], 1'b0} ^ (r[22] ? POLY23 : '0);
    end
    return k;
  endfunction

  function automatic logic is_short_os(input logic [7:0] b);
    return (b == 8'h1C) || (b == 8'h3C) || (b == 8'h7C) || (b == 8'hFC);
  endfunction

  // One byte through the descrambler; returns the next lane state.
  // A TS set is recognised only by a non-short-OS K symbol right after COM;
  // a D byte after COM is ordinary scrambled data.
  function automatic lane_state_t proc_byte(input  lane_state_t s,
                                            input  logic        gen3,
                                            input  logic        os_hdr,
                                            input  logic [7:0]  din,
                                            input  logic        kin,
                                            input  logic [22:0] seed,
                                            output logic [7:0]  dout);
    lane_state_t n;
    n    = s;
    dout = din;
    if (!gen3) begin
      n.com_seen = 1'b0;
      if (kin && din == K_COM) begin
        n.l16      = '1;
        n.ts_cnt   = '0;
        n.com_seen = 1'b1;
      end else if (s.ts_cnt != 4'd0) begin
        n.l16    = adv16(s.l16);
        n.ts_cnt = s.ts_cnt - 4'd1;
      end else if (kin) begin
        if (s.com_seen && !is_short_os(din)) begin
          n.l16    = adv16(s.l16);
          n.ts_cnt = 4'd14;
        end else if (din != K_SKP) begin
          n.l16 = adv16(s.l16);
        end
      end else begin
        dout  = din ^ key16(s.l16);
        n.l16 = adv16(s.l16);
      end
    end else begin
      if (s.byte_cnt == 4'd0) begin
        n.blk_os = os_hdr;
        n.os_skp = os_hdr && (din == OS_SKP);
        n.os_eie = os_hdr && (din == OS_EIE);
      end
      if (n.blk_os && (n.os_skp || n.os_eie)) begin
        dout = din;
      end else if (n.blk_os && s.byte_cnt == 4'd0) begin
        n.l23 = adv23(s.l23);
      end else begin
        dout  = din ^ key23(s.l23);
        n.l23 = adv23(s.l23);
      end
      if (s.byte_cnt == 4'd15 && n.blk_os && n.os_eie) n.l23 = seed;
      n.byte_cnt = s.byte_cnt + 4'd1;
    end
    return n;
  endfunction

  lane_state_t st_q, st_d, st_w;
  logic        seed_load_q, seed_load_d;
  logic        gen3_q, gen3_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  k_q, k_d;
  logic [1:0]  sync_q, sync_d;
  logic [3:0]  act;
  logic [31:0] byte_mask;
  logic        new_gen3, os_hdr;
  logic [7:0]  ob0, ob1, ob2, ob3;
  logic        seed_unused;

  // Active byte lanes from PIPEWIDTH; anything other than 8/16 means 32.
  always_comb begin
    case (PIPEWIDTH)
      6'd8:    act = 4'b0001;
      6'd16:   act = 4'b0011;
      default: act = 4'b1111;
    endcase
    byte_mask   = {{8{act[3]}}, {8{act[2]}}, {8{act[1]}}, {8{act[0]}}};
    new_gen3    = |PIPESyncHeader;
    os_hdr      = (PIPESyncHeader == 2'b01);
    seed_unused = seedValue[23];
  end

  // Next lane state and output word: bypass, hold on invalid, or descramble bytes in order.
  always_comb begin
    st_d        = st_q;
    st_w        = st_q;
    seed_load_d = seed_load_q;
    gen3_d      = gen3_q;
    valid_d     = PIPEDataValid;
    sync_d      = PIPESyncHeader;
    data_d      = '0;
    k_d         = '0;
    ob0         = '0;
    ob1         = '0;
    ob2         = '0;
    ob3         = '0;
    if (turnOff) begin
      st_d        = ST_INIT;
      seed_load_d = 1'b1;
      if (PIPEDataValid) begin
        data_d = PIPEData & byte_mask;
        k_d    = PIPEDataK;
      end
    end else if (PIPEDataValid) begin
      // LFSR23 is loaded lazily from the live seed on first use after reset/bypass
      if (seed_load_q) st_w.l23 = seedValue[22:0];
      if (new_gen3 != gen3_q) begin
        st_w     = ST_INIT;
        st_w.l23 = seedValue[22:0];
      end
      if (act[0]) st_w = proc_byte(st_w, new_gen3, os_hdr, PIPEData[7:0],   PIPEDataK[0], seedValue[22:0], ob0);
      if (act[1]) st_w = proc_byte(st_w, new_gen3, os_hdr, PIPEData[15:8],  PIPEDataK[1], seedValue[22:0], ob1);
      if (act[2]) st_w = proc_byte(st_w, new_gen3, os_hdr, PIPEData[23:16], PIPEDataK[2], seedValue[22:0], ob2);
      if (act[3]) st_w = proc_byte(st_w, new_gen3, os_hdr, PIPEData[31:24], PIPEDataK[3], seedValue[22:0], ob3);
      st_d        = st_w;
      seed_load_d = 1'b0;
      gen3_d      = new_gen3;
      data_d      = {ob3, ob2, ob1, ob0};
      k_d         = PIPEDataK;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= ST_INIT;
      seed_load_q <= 1'b1;
      gen3_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      k_q         <= '0;
      sync_q      <= '0;
    end else begin
      st_q        <= st_d;
      seed_load_q <= seed_load_d;
      gen3_q      <= gen3_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      k_q         <= k_d;
      sync_q      <= sync_d;
    end
  end

  assign descramblerDataValid  = valid_q;
  assign descramblerData       = data_q;
  assign descramblerDataK      = k_q;
  assign descramblerSyncHeader = sync_q;

endmodule

// File: tb/tb_pcie_rx_lane_descrambler.sv
// Self-checking bench for pcie_rx_lane_descrambler: directed cases plus randomized
// streams compared against a keystream-offset reference model.
`timescale 1ns/1ps
module tb_pcie_rx_lane_descrambler;

  logic        clk = 1'b0;
  logic        reset;
  logic        turnOff;
  logic        PIPEDataValid;
  logic [5:0]  PIPEWIDTH;
  logic [1:0]  PIPESyncHeader;
  logic [23:0] seedValue;
  logic [31:0] PIPEData;
  logic [3:0]  PIPEDataK;
  logic        descramblerDataValid;
  logic [31:0] descramblerData;
  logic [3:0]  descramblerDataK;
  logic [1:0]  descramblerSyncHeader;

  pcie_rx_lane_descrambler dut (
    .clk                   (clk),
    .reset                 (reset),
    .turnOff               (turnOff),
    .PIPEDataValid         (PIPEDataValid),
    .PIPEWIDTH             (PIPEWIDTH),
    .PIPESyncHeader        (PIPESyncHeader),
    .seedValue             (seedValue),
    .PIPEData              (PIPEData),
    .PIPEDataK             (PIPEDataK),
    .descramblerDataValid  (descramblerDataValid),
    .descramblerData       (descramblerData),
    .descramblerDataK      (descramblerDataK),
    .descramblerSyncHeader (descramblerSyncHeader)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: scramblers are tracked as byte offsets since their last reload.
  logic        m_gen3;
  int unsigned m_pos16, m_pos23, m_ts, m_bcnt;
  logic [22:0] m_seed23;
  logic        m_com, m_os, m_skp, m_eie;

  logic        exp_valid;
  logic [31:0] exp_data;
  logic [3:0]  exp_k;
  logic [1:0]  exp_sync;

  // Keystream byte at a given byte offset from the 16'hFFFF start state.
  function automatic logic [7:0] ks16(input int unsigned pos);
    logic [16:0] poly;
    logic [15:0] s;
    logic [7:0]  r;
    poly = 17'h10039;
    s    = 16'hFFFF;
    r    = '0;
    for (int unsigned i = 0; i < pos * 8 + 8; i++) begin
      if (i >= pos * 8) r = {s[15], r[7:1]};
      s = {s[14:0], 1'b0} ^ (s[15] ? poly[15:0] : 16'h0000);
    end
    return r;
  endfunction

  // Keystream byte at a given byte offset from a Gen3 seed.
  function automatic logic [7:0] ks23(input logic [22:0] seed, input int unsigned pos);
    logic [23:0] poly;
    logic [22:0] s;
    logic [7:0]  r;
    poly = 24'hA10125;
    s    = seed;
    r    = '0;
    for (int unsigned i = 0; i < pos * 8 + 8; i++) begin
      if (i >= pos * 8) r = {s[22], r[7:1]};
      s = {s[21:0], 1'b0} ^ (s[22] ? poly[22:0] : 23'h0);
    end
    return r;
  endfunction

  task automatic model_restart();
    m_pos16  = 0;
    m_pos23  = 0;
    m_seed23 = seedValue[22:0];
    m_com    = 1'b0;
    m_ts     = 0;
    m_bcnt   = 0;
    m_os     = 1'b0;
    m_skp    = 1'b0;
    m_eie    = 1'b0;
  endtask

  task automatic model_reset();
    model_restart();
    m_gen3 = 1'b0;
  endtask

  task automatic model_cycle(input logic v, input logic [5:0] w, input logic [1:0] hdr,
                             input logic [31:0] din, input logic [3:0] kin, input logic toff);
    int unsigned n;
    logic [7:0]  b, o;
    logic        kb;
    n = (w == 6'd8) ? 1 : (w == 6'd16) ? 2 : 4;
    exp_valid = v;
    exp_sync  = hdr;
    exp_k     = v ? kin : 4'h0;
    exp_data  = '0;
    if (toff) begin
      model_restart();
      if (v) for (int unsigned i = 0; i < n; i++) exp_data[8*i +: 8] = din[8*i +: 8];
      return;
    end
    if (!v) return;
    if ((hdr != 2'b00) != m_gen3) begin
      model_restart();
      m_gen3 = (hdr != 2'b00);
    end
    for (int unsigned i = 0; i < n; i++) begin
      b  = din[8*i +: 8];
      kb = kin[i];
      o  = b;
      if (!m_gen3) begin
        if (kb && b == 8'hBC) begin
          m_pos16 = 0;
          m_ts    = 0;
        end else if (m_ts > 0) begin
          m_pos16++;
          m_ts--;
        end else if (kb) begin
          if (m_com && !(b inside {8'h1C, 8'h3C, 8'h7C, 8'hFC})) begin
            m_pos16++;
            m_ts = 14;
          end else if (b != 8'h1C) begin
            m_pos16++;
          end
        end else begin
          o = b ^ ks16(m_pos16);
          m_pos16++;
        end
        m_com = kb && (b == 8'hBC);
      end else begin
        if (m_bcnt == 0) begin
          m_os  = (hdr == 2'b01);
          m_skp = m_os && (b == 8'hAA);
          m_eie = m_os && (b == 8'h00);
        end
        if (m_os && (m_skp || m_eie)) begin
          o = b;
        end else if (m_os && m_bcnt == 0) begin
          m_pos23++;
        end else begin
          o = b ^ ks23(m_seed23, m_pos23);
          m_pos23++;
        end
        if (m_bcnt == 15 && m_os && m_eie) begin
          m_seed23 = seedValue[22:0];
          m_pos23  = 0;
        end
        m_bcnt = (m_bcnt + 1) % 16;
      end
      exp_data[8*i +: 8] = o;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic v, input logic [5:0] w, input logic [1:0] hdr,
                      input logic [31:0] din, input logic [3:0] kin, input logic toff);
    PIPEDataValid  = v;
    PIPEWIDTH      = w;
    PIPESyncHeader = hdr;
    PIPEData       = din;
    PIPEDataK      = kin;
    turnOff        = toff;
    model_cycle(v, w, hdr, din, kin, toff);
    @(posedge clk);
    #1;
    chk("valid", {31'd0, descramblerDataValid}, {31'd0, exp_valid});
    chk("data", descramblerData, exp_data);
    chk("k", {28'd0, descramblerDataK}, {28'd0, exp_k});
    if (exp_valid) chk("sync", {30'd0, descramblerSyncHeader}, {30'd0, exp_sync});
  endtask

  task automatic pick8b10b(output logic [7:0] b, output logic k);
    int unsigned r;
    r = $urandom_range(0, 99);
    k = 1'b1;
    if (r < 8) b = 8'hBC;
    else if (r < 14) b = 8'h1C;
    else if (r < 20) begin
      case ($urandom_range(0, 4))
        0: b = 8'h3C;
        1: b = 8'h7C;
        2: b = 8'hFC;
        3: b = 8'hF7;
        default: b = 8'hFE;
      endcase
    end else begin
      b = 8'($urandom);
      k = 1'b0;
    end
  endtask

  function automatic logic [5:0] pick_width();
    case ($urandom_range(0, 4))
      0: return 6'd8;
      1: return 6'd16;
      2: return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  logic [31:0] w32, saved;
  logic [3:0]  k4;
  logic [7:0]  rb;
  logic        rk;

  initial begin
    reset = 1'b1; turnOff = 1'b0; PIPEDataValid = 1'b1; PIPEWIDTH = 6'd32;
    PIPESyncHeader = 2'b10; seedValue = 24'h0; PIPEData = 32'hDEADBEEF; PIPEDataK = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, descramblerDataValid}, 32'd0);
    chk("rst_data", descramblerData, 32'd0);
    chk("rst_k", {28'd0, descramblerDataK}, 32'd0);
    chk("rst_sync", {30'd0, descramblerSyncHeader}, 32'd0);
    reset = 1'b0;
    model_reset();

    // COM then two zero data bytes, byte-wide
    step(1, 6'd8, 2'b00, 32'h000000BC, 4'b0001, 0);
    chk("com_pass", descramblerData, 32'h000000BC);
    chk("com_k", {28'd0, descramblerDataK}, 32'd1);
    step(1, 6'd8, 2'b00, $urandom & 32'hFFFFFF00, 4'b0000, 0);
    chk("ks_b0", descramblerData, 32'h000000FF);
    step(1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("ks_b1", descramblerData, 32'h00000017);

    // 32-bit words
    step(1, 6'd32, 2'b00, 32'h000000BC, 4'b0001, 0);
    chk("w32_0", descramblerData, 32'hC017FFBC);
    step(1, 6'd32, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("w32_1", descramblerData, 32'h02E7B214);

    // SKPs after COM leave the scrambler parked
    step(1, 6'd8, 2'b00, 32'h000000BC, 4'b0001, 0);
    repeat (3) step(1, 6'd8, 2'b00, 32'h0000001C, 4'b0001, 0);
    chk("skp_pass", descramblerData, 32'h0000001C);
    step(1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("skp_then_d", descramblerData, 32'h000000FF);

    // TS ordered set: 16 bytes in the clear
    step(1, 6'd32, 2'b00, 32'hAAF7F7BC, 4'b0111, 0);
    chk("ts_w0", descramblerData, 32'hAAF7F7BC);
    for (int i = 0; i < 3; i++) begin
      w32 = $urandom;
      step(1, 6'd32, 2'b00, w32, 4'b0000, 0);
      chk("ts_clear", descramblerData, w32);
    end
    step(1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("ts_after", descramblerData, {24'd0, ks16(15)});

    // Valid dropped between words
    step(1, 6'd32, 2'b00, 32'h000000BC, 4'b0001, 0);
    chk("gap_w0", descramblerData, 32'hC017FFBC);
    step(0, 6'd32, 2'b00, $urandom, 4'b1111, 0);
    chk("gap_data", descramblerData, 32'd0);
    step(1, 6'd32, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("gap_w1", descramblerData, 32'h02E7B214);

    // Bypass
    for (int i = 0; i < 4; i++) begin
      w32 = $urandom;
      k4  = 4'($urandom);
      step(1, 6'd32, 2'b00, w32, k4, 1);
      chk("bypass", descramblerData, w32);
    end
    step(1, 6'd8, 2'b00, 32'h000000BC, 4'b0001, 0);
    step(1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("bypass_exit", descramblerData, 32'h000000FF);

    // Gen3 with zero seed: identity
    for (int i = 0; i < 4; i++) begin
      w32 = $urandom;
      step(1, 6'd32, 2'b10, w32, 4'($urandom), 0);
      chk("g3_zero_seed", descramblerData, w32);
    end
    // Nonzero seed, loaded through a bypass cycle; SKP OS block then data block
    seedValue = 24'h3A5C91;
    step(1, 6'd32, 2'b01, $urandom, 4'b0000, 1);
    for (int i = 0; i < 4; i++) begin
      w32 = $urandom;
      if (i == 0) w32[7:0] = 8'hAA;
      step(1, 6'd32, 2'b01, w32, 4'b0000, 0);
      chk("g3_skp_os", descramblerData, w32);
    end
    saved = $urandom;
    step(1, 6'd32, 2'b10, saved, 4'b0000, 0);
    w32 = saved ^ {ks23(23'h3A5C91, 3), ks23(23'h3A5C91, 2), ks23(23'h3A5C91, 1), ks23(23'h3A5C91, 0)};
    chk("g3_seed_start", descramblerData, w32);
    for (int i = 0; i < 3; i++) step(1, 6'd32, 2'b10, $urandom, 4'b0000, 0);

    // Random 8b/10b stream
    for (int c = 0; c < 120; c++) begin
      w32 = '0;
      k4  = '0;
      for (int j = 0; j < 4; j++) begin
        pick8b10b(rb, rk);
        w32[8*j +: 8] = rb;
        k4[j] = rk;
      end
      step(($urandom_range(0, 9) != 0), pick_width(), 2'b00, w32, k4, ($urandom_range(0, 39) == 0));
    end

    // Random 128b/130b stream with SKP/EIEOS/other blocks
    for (int c = 0; c < 120; c++) begin
      w32 = $urandom;
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 5))
          0: w32[8*j +: 8] = 8'hAA;
          1: w32[8*j +: 8] = 8'h00;
          default: ;
        endcase
      end
      step(($urandom_range(0, 9) != 0), pick_width(), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
           w32, 4'($urandom), 1'b0);
    end

    // Asynchronous reset mid-stream
    step(1, 6'd32, 2'b00, $urandom, 4'b0000, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, descramblerDataValid}, 32'd0);
    chk("async_data", descramblerData, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1, 6'd8, 2'b00, 32'h000000BC, 4'b0001, 0);
    step(1, 6'd8, 2'b00, 32'h00000000, 4'b0000, 0);
    chk("post_reset", descramblerData, 32'h000000FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
